// File: rtl/writeback_stage.sv
// Writeback stage: retires memory-stage results into the register file, waiting on and extracting load data.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              ws_clk,
    input  logic              ws_rst,
    input  logic              ws_i_ce,
    input  logic [AWIDTH-1:0] ws_i_addr_rd,
    input  logic              ws_i_wr_rd,
    input  logic              ws_i_load,
    input  logic [2:0]        ws_i_funct3,
    input  logic [DWIDTH-1:0] ws_i_alu_result,
    input  logic [DWIDTH-1:0] ws_i_load_data,
    input  logic              ws_i_rd_ack,
    input  logic              ws_i_stall,
    input  logic              ws_i_flush,
    output logic [AWIDTH-1:0] ws_o_addr_rd,
    output logic [DWIDTH-1:0] ws_o_data_rd,
    output logic              ws_o_we,
    output logic              ws_o_ce,
    output logic              ws_o_stall,
    output logic [63:0]       ws_o_retired
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    logic [0:0]        state_reg;
    logic [AWIDTH-1:0] rd_reg;
    logic              wr_rd_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        offset_reg;
    logic [AWIDTH-1:0] addr_rd_reg;
    logic [DWIDTH-1:0] data_rd_reg;
    logic              we_reg;
    logic              ce_reg;

    // Byte and halfword lanes of the returned word, selected by the latched offset.
    logic [7:0]        byte_lane [DWIDTH/8];
    logic [15:0]       half_lane [DWIDTH/16];
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] load_value;

    generate
        for (genvar gi = 0; gi < DWIDTH/8; gi++) begin : g_byte
            assign byte_lane[gi] = ws_i_load_data[8*gi +: 8];
        end
        for (genvar gi = 0; gi < DWIDTH/16; gi++) begin : g_half
            assign half_lane[gi] = ws_i_load_data[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[offset_reg];
    assign half_sel = half_lane[offset_reg[1]];

    always_comb begin
        load_value = ws_i_load_data;
        case (funct3_reg)
            3'b000:  load_value = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_value = {{(DWIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_value = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_value = {{(DWIDTH-16){1'b0}}, half_sel};
            default: load_value = ws_i_load_data;
        endcase
    end

    always_ff @(posedge ws_clk) begin
        if (ws_rst) begin
            state_reg   <= IDLE;
            rd_reg      <= '0;
            wr_rd_reg   <= 1'b0;
            funct3_reg  <= 3'b000;
            offset_reg  <= 2'b00;
            addr_rd_reg <= '0;
            data_rd_reg <= '0;
            we_reg      <= 1'b0;
            ce_reg      <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            ce_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (ws_i_ce && !ws_i_stall && !ws_i_flush) begin
                    if (ws_i_load) begin
                        rd_reg     <= ws_i_addr_rd;
                        wr_rd_reg  <= ws_i_wr_rd;
                        funct3_reg <= ws_i_funct3;
                        offset_reg <= ws_i_alu_result[1:0];
                        state_reg  <= WAIT_LOAD;
                    end else begin
                        addr_rd_reg <= ws_i_addr_rd;
                        data_rd_reg <= ws_i_alu_result;
                        we_reg      <= ws_i_wr_rd && (ws_i_addr_rd != '0);
                        ce_reg      <= 1'b1;
                    end
                end
            end else begin
                // Flush wins over a same-cycle ack: the load is dropped silently.
                if (ws_i_flush) begin
                    state_reg <= IDLE;
                end else if (ws_i_rd_ack) begin
                    addr_rd_reg <= rd_reg;
                    data_rd_reg <= load_value;
                    we_reg      <= wr_rd_reg && (rd_reg != '0);
                    ce_reg      <= 1'b1;
                    state_reg   <= IDLE;
                end
            end
        end
    end

    assign ws_o_addr_rd = addr_rd_reg;
    assign ws_o_data_rd = data_rd_reg;
    assign ws_o_we      = we_reg;
    assign ws_o_ce      = ce_reg;
    assign ws_o_stall   = ws_i_stall || (state_reg == WAIT_LOAD);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_reg;

    always_ff @(posedge ws_clk) begin
        if (ws_rst) begin
            retired_reg <= '0;
        end else if (ce_reg) begin
            retired_reg <= retired_reg + 64'd1;
        end
    end

    assign ws_o_retired = retired_reg;
`else
    assign ws_o_retired = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized traffic against a transaction-level model.
module tb_writeback_stage;
    logic        ws_clk = 1'b0;
    logic        ws_rst;
    logic        ws_i_ce;
    logic [4:0]  ws_i_addr_rd;
    logic        ws_i_wr_rd;
    logic        ws_i_load;
    logic [2:0]  ws_i_funct3;
    logic [31:0] ws_i_alu_result;
    logic [31:0] ws_i_load_data;
    logic        ws_i_rd_ack;
    logic        ws_i_stall;
    logic        ws_i_flush;
    logic [4:0]  ws_o_addr_rd;
    logic [31:0] ws_o_data_rd;
    logic        ws_o_we;
    logic        ws_o_ce;
    logic        ws_o_stall;
    logic [63:0] ws_o_retired;

    always #5 ws_clk = ~ws_clk;

    writeback_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
        .ws_clk(ws_clk), .ws_rst(ws_rst),
        .ws_i_ce(ws_i_ce), .ws_i_addr_rd(ws_i_addr_rd), .ws_i_wr_rd(ws_i_wr_rd),
        .ws_i_load(ws_i_load), .ws_i_funct3(ws_i_funct3), .ws_i_alu_result(ws_i_alu_result),
        .ws_i_load_data(ws_i_load_data), .ws_i_rd_ack(ws_i_rd_ack), .ws_i_stall(ws_i_stall),
        .ws_i_flush(ws_i_flush), .ws_o_addr_rd(ws_o_addr_rd), .ws_o_data_rd(ws_o_data_rd),
        .ws_o_we(ws_o_we), .ws_o_ce(ws_o_ce), .ws_o_stall(ws_o_stall), .ws_o_retired(ws_o_retired)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] rd;
        logic       wr;
        logic [2:0] f3;
        logic [1:0] off;
    } pend_t;

    pend_t       pend_q[$];
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;
    logic        m_ce;
    logic [63:0] m_ret;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load extraction from the arithmetic meaning of byte/half selection.
    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (int'(w) >>> 0) == 0 ? 0 : 0;
        b = (32'(w) >> (8 * int'(off))) % 256;
        h = (32'(w) >> (16 * (int'(off) / 2))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic retire(input logic [4:0] rd, input logic wr, input logic [31:0] val);
        m_addr = rd;
        m_data = val;
        m_we   = wr && (rd != 5'd0);
        m_ce   = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs held during this cycle.
    task automatic model_edge();
        pend_t p;
        if (ws_rst) begin
            pend_q.delete();
            m_addr = 5'd0; m_data = 32'd0; m_we = 1'b0; m_ce = 1'b0; m_ret = 64'd0;
            return;
        end
`ifdef WB_RETIRE_CNT_EN
        if (m_ce) m_ret = m_ret + 64'd1;
`endif
        m_we = 1'b0;
        m_ce = 1'b0;
        if (ws_i_flush) begin
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            if (ws_i_rd_ack) begin
                p = pend_q.pop_front();
                retire(p.rd, p.wr, ref_extract(p.f3, p.off, ws_i_load_data));
            end
        end else if (ws_i_ce && !ws_i_stall) begin
            if (ws_i_load) begin
                p.rd = ws_i_addr_rd; p.wr = ws_i_wr_rd; p.f3 = ws_i_funct3; p.off = ws_i_alu_result[1:0];
                pend_q.push_back(p);
            end else begin
                retire(ws_i_addr_rd, ws_i_wr_rd, ws_i_alu_result);
            end
        end
    endtask

    task automatic cycle();
        @(posedge ws_clk);
        model_edge();
        #1;
        check_val("we", 64'(ws_o_we), 64'(m_we));
        check_val("ce", 64'(ws_o_ce), 64'(m_ce));
        check_val("addr", 64'(ws_o_addr_rd), 64'(m_addr));
        check_val("data", 64'(ws_o_data_rd), 64'(m_data));
        check_val("stall", 64'(ws_o_stall), 64'(ws_i_stall || (pend_q.size() != 0)));
        check_val("retired", ws_o_retired, m_ret);
        if (m_ce) $display("retire rd=%0d data=0x%08h we=%0b", m_addr, m_data, m_we);
        @(negedge ws_clk);
    endtask

    task automatic idle_inputs();
        ws_rst = 1'b0; ws_i_ce = 1'b0; ws_i_addr_rd = 5'd0; ws_i_wr_rd = 1'b0; ws_i_load = 1'b0;
        ws_i_funct3 = 3'd0; ws_i_alu_result = 32'd0; ws_i_load_data = 32'd0; ws_i_rd_ack = 1'b0;
        ws_i_stall = 1'b0; ws_i_flush = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic ld, input logic [2:0] f3, input logic [31:0] alu);
        ws_i_ce = 1'b1; ws_i_addr_rd = rd; ws_i_wr_rd = wr; ws_i_load = ld;
        ws_i_funct3 = f3; ws_i_alu_result = alu;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word, input logic [31:0] exp, input string tag);
        issue(5'd7, 1'b1, 1'b1, f3, 32'h0000_1000 | 32'(off));
        cycle();
        ws_i_ce = 1'b0; ws_i_rd_ack = 1'b1; ws_i_load_data = word;
        cycle();
        check_val(tag, 64'(ws_o_data_rd), 64'(exp));
        ws_i_rd_ack = 1'b0;
        cycle();
    endtask

    int stall_cnt;
    int we_cnt;

    initial begin
        idle_inputs();
        m_addr = 5'd0; m_data = 32'd0; m_we = 1'b0; m_ce = 1'b0; m_ret = 64'd0;
        @(negedge ws_clk);
        ws_rst = 1'b1;
        cycle();
        check_val("rst_data", 64'(ws_o_data_rd), 64'd0);
        check_val("rst_we", 64'(ws_o_we), 64'd0);
        ws_rst = 1'b0;
        cycle();

        // Plain ALU writeback and x0 write.
        issue(5'd5, 1'b1, 1'b0, 3'd0, 32'h1234_5678);
        cycle();
        check_val("nl_we", 64'(ws_o_we), 64'd1);
        check_val("nl_data", 64'(ws_o_data_rd), 64'h1234_5678);
        ws_i_ce = 1'b0;
        cycle();
        check_val("nl_we_drop", 64'(ws_o_we), 64'd0);
        issue(5'd0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF);
        cycle();
        check_val("x0_we", 64'(ws_o_we), 64'd0);
        check_val("x0_ce", 64'(ws_o_ce), 64'd1);
        ws_i_ce = 1'b0;
        cycle();

        do_load(3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80, "lb");
        do_load(3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080, "lbu");
        do_load(3'b001, 2'd2, 32'h80FF_1234, 32'hFFFF_80FF, "lh");
        do_load(3'b101, 2'd2, 32'h80FF_1234, 32'h0000_80FF, "lhu");
        do_load(3'b010, 2'd0, 32'h80FF_1234, 32'h80FF_1234, "lw");

        // Delayed ack: further ce is ignored while the load is pending.
        stall_cnt = 0; we_cnt = 0;
        issue(5'd9, 1'b1, 1'b1, 3'b010, 32'h0000_2000);
        cycle();
        stall_cnt += int'(ws_o_stall);
        issue(5'd10, 1'b1, 1'b0, 3'd0, 32'h5555_AAAA);
        for (int i = 0; i < 3; i++) begin
            cycle();
            stall_cnt += int'(ws_o_stall);
            we_cnt    += int'(ws_o_we);
        end
        ws_i_ce = 1'b0; ws_i_rd_ack = 1'b1; ws_i_load_data = 32'hCAFE_0001;
        cycle();
        stall_cnt += int'(ws_o_stall);
        we_cnt    += int'(ws_o_we);
        ws_i_rd_ack = 1'b0;
        cycle();
        we_cnt += int'(ws_o_we);
        check_val("dly_stall_cycles", 64'(stall_cnt), 64'd4);
        check_val("dly_we_pulses", 64'(we_cnt), 64'd1);

        // Flush together with ack, then reset mid-load.
        issue(5'd11, 1'b1, 1'b1, 3'b010, 32'h0000_3000);
        cycle();
        ws_i_ce = 1'b0; ws_i_rd_ack = 1'b1; ws_i_flush = 1'b1;
        cycle();
        check_val("flush_we", 64'(ws_o_we), 64'd0);
        check_val("flush_stall", 64'(ws_o_stall), 64'd0);
        ws_i_rd_ack = 1'b0; ws_i_flush = 1'b0;
        issue(5'd12, 1'b1, 1'b1, 3'b010, 32'h0000_3004);
        cycle();
        ws_i_ce = 1'b0; ws_rst = 1'b1;
        cycle();
        check_val("rst_wait_addr", 64'(ws_o_addr_rd), 64'd0);
        check_val("rst_wait_stall", 64'(ws_o_stall), 64'd0);
        ws_rst = 1'b0; ws_i_rd_ack = 1'b1;
        cycle();
        check_val("rst_wait_ack_ignored", 64'(ws_o_we), 64'd0);
        ws_i_rd_ack = 1'b0;

        // Ten back-to-back retirements, one of them to x0.
        for (int i = 0; i < 10; i++) begin
            issue((i == 4) ? 5'd0 : 5'(i + 1), 1'b1, 1'b0, 3'd0, 32'(i * 17));
            cycle();
        end
        ws_i_ce = 1'b0;
        cycle();
`ifdef WB_RETIRE_CNT_EN
        check_val("retired_10", ws_o_retired, 64'd10);
`else
        check_val("retired_off", ws_o_retired, 64'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ws_rst          = ($urandom_range(0, 59) == 0);
            ws_i_ce         = ($urandom_range(0, 9) < 7);
            ws_i_addr_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ws_i_wr_rd      = ($urandom_range(0, 4) != 0);
            ws_i_load       = ($urandom_range(0, 9) < 4);
            ws_i_funct3     = 3'($urandom_range(0, 7));
            ws_i_alu_result = $urandom;
            ws_i_load_data  = $urandom;
            ws_i_rd_ack     = ($urandom_range(0, 9) < 4);
            ws_i_stall      = ($urandom_range(0, 19) < 3);
            ws_i_flush      = ($urandom_range(0, 24) < 2);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
